// File: rtl/trig_capture_ctrl.sv
// ============================================================================
// Module      : trig_capture_ctrl
// Description : Trigger-driven acquisition controller. While armed, ADC words
//               are recorded into a circular buffer of DEPTH = 2**ADDR_WIDTH
//               words. A trigger (TriggerIn rising edge or ForceTrigger) is
//               accepted once enough pre-trigger samples exist. The buffer
//               then fills with post-trigger samples, freezes, and is streamed
//               out one word per accepted ReadEnable.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   Clock_i            single clock
//   Reset_i            asynchronous, active-high reset
//   DataIn_i           sample word
//   DataInValid_i      DataIn_i is written this cycle when recording
//   Arm_i              pulse: start recording (IDLE only)
//   Disarm_i           pulse: abort, return to IDLE, discard record
//   ForceTrigger_i     pulse: software trigger
//   TriggerIn_i        synchronised comparator output, rising edge triggers
//   PreTrigCount_i     number of pre-trigger samples, sampled on arm
//   AutoRearm_i        re-enter ARMED after readout instead of IDLE
//   ReadEnable_i       consumer read strobe
//   DataOut_o          read word (1-cycle latency)
//   DataValid_o        single-cycle pulse qualifying DataOut_o
//   DataReadyToSend_o  record words remain to be read
//   Triggered_o        trigger accepted, record not yet fully read
//   Overrun_o          sticky: trigger edge seen while not accepting
//   State_o            0 IDLE, 1 ARMED, 2 POSTTRIG, 3 READOUT
//   TrigTimestamp_o    free-running count latched at trigger accept
// Optional feature:
//   TRIG_TIMESTAMP_EN  when defined, a TS_WIDTH free-running counter is
//                      latched into TrigTimestamp_o on trigger accept;
//                      otherwise TrigTimestamp_o is tied to zero.
// ============================================================================
`default_nettype none

module trig_capture_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TS_WIDTH   = 32
) (
    input  logic                  Clock_i,
    input  logic                  Reset_i,
    input  logic [DATA_WIDTH-1:0] DataIn_i,
    input  logic                  DataInValid_i,
    input  logic                  Arm_i,
    input  logic                  Disarm_i,
    input  logic                  ForceTrigger_i,
    input  logic                  TriggerIn_i,
    input  logic [ADDR_WIDTH-1:0] PreTrigCount_i,
    input  logic                  AutoRearm_i,
    input  logic                  ReadEnable_i,
    output logic [DATA_WIDTH-1:0] DataOut_o,
    output logic                  DataValid_o,
    output logic                  DataReadyToSend_o,
    output logic                  Triggered_o,
    output logic                  Overrun_o,
    output logic [1:0]            State_o,
    output logic [TS_WIDTH-1:0]   TrigTimestamp_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_POSTTRIG = 2'd2;
    localparam logic [1:0] S_READOUT  = 2'd3;

    localparam int                  c_depth_words = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth       = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_one         = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Record buffer (synchronous dual-port RAM, no reset)
    logic [DATA_WIDTH-1:0] mem_q [0:c_depth_words-1];

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [ADDR_WIDTH-1:0] wp_q;
    logic [ADDR_WIDTH-1:0] pre_q;
    logic [ADDR_WIDTH-1:0] start_q;
    logic [ADDR_WIDTH-1:0] rp_q;
    logic [ADDR_WIDTH-1:0] rcnt_q;
    logic [ADDR_WIDTH:0]   fill_q;
    logic [ADDR_WIDTH:0]   post_q;
    logic                  trig_prev_q;
    logic                  triggered_q;
    logic                  overrun_q;
    logic                  dvalid_q;
    logic [DATA_WIDTH-1:0] dout_q;

    logic                  w_trig_ev;
    logic                  w_fill_ok;
    logic                  w_accept;
    logic                  w_rd_acc;
    logic                  w_rearm;
    logic                  w_enter_ro;
    logic                  w_we;
    logic [ADDR_WIDTH:0]   w_post_init;
    logic [ADDR_WIDTH-1:0] w_start;

    assign w_trig_ev = (TriggerIn_i & ~trig_prev_q) | ForceTrigger_i;
    assign w_fill_ok = (fill_q >= {1'b0, pre_q});
    // Start address uses the write pointer before this cycle's write, so a
    // word written in the accept cycle is the trigger sample itself.
    assign w_start   = wp_q - pre_q;
    // Post samples still needed after the accept cycle; the accept-cycle
    // write (if any) is already the first post sample.
    assign w_post_init = c_depth - {1'b0, pre_q} - {{ADDR_WIDTH{1'b0}}, DataInValid_i};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and transition strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        w_accept   = 1'b0;
        w_rd_acc   = 1'b0;
        w_rearm    = 1'b0;
        w_enter_ro = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Arm_i) begin
                    state_d = S_ARMED;
                    w_rearm = 1'b1;
                end
            end
            S_ARMED: begin
                if (w_trig_ev && w_fill_ok) begin
                    w_accept = 1'b1;
                    // Maximum pre-trigger with a valid accept-cycle word
                    // completes the record immediately.
                    if (w_post_init == '0) begin
                        state_d    = S_READOUT;
                        w_enter_ro = 1'b1;
                    end else begin
                        state_d = S_POSTTRIG;
                    end
                end
            end
            S_POSTTRIG: begin
                if (DataInValid_i && (post_q == c_one)) begin
                    state_d    = S_READOUT;
                    w_enter_ro = 1'b1;
                end
            end
            S_READOUT: begin
                if (ReadEnable_i) begin
                    w_rd_acc = 1'b1;
                    if (rcnt_q == {ADDR_WIDTH{1'b1}}) begin
                        if (AutoRearm_i) begin
                            state_d = S_ARMED;
                            w_rearm = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Disarm overrides every other request, including a read.
        if (Disarm_i) begin
            state_d    = S_IDLE;
            w_accept   = 1'b0;
            w_rd_acc   = 1'b0;
            w_rearm    = 1'b0;
            w_enter_ro = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output / decode logic
    // ------------------------------------------------------------------
    always_comb begin
        w_we              = DataInValid_i && ((state_q == S_ARMED) || (state_q == S_POSTTRIG));
        DataReadyToSend_o = (state_q == S_READOUT);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            wp_q        <= '0;
            pre_q       <= '0;
            start_q     <= '0;
            rp_q        <= '0;
            rcnt_q      <= '0;
            fill_q      <= '0;
            post_q      <= '0;
            trig_prev_q <= 1'b0;
            triggered_q <= 1'b0;
            overrun_q   <= 1'b0;
            dvalid_q    <= 1'b0;
            dout_q      <= '0;
        end else begin
            trig_prev_q <= TriggerIn_i;
            dvalid_q    <= w_rd_acc;
            triggered_q <= (state_d == S_POSTTRIG) || (state_d == S_READOUT);

            if (w_rearm) begin
                wp_q   <= '0;
                fill_q <= '0;
                pre_q  <= PreTrigCount_i;
            end else if (w_we) begin
                wp_q <= wp_q + ADDR_WIDTH'(1);
                if (fill_q != c_depth) begin
                    fill_q <= fill_q + c_one;
                end
            end

            if (w_accept) begin
                start_q <= w_start;
                post_q  <= w_post_init;
            end else if (w_we && (state_q == S_POSTTRIG)) begin
                post_q <= post_q - c_one;
            end

            if (w_enter_ro) begin
                rp_q   <= w_accept ? w_start : start_q;
                rcnt_q <= '0;
            end else if (w_rd_acc) begin
                rp_q   <= rp_q + ADDR_WIDTH'(1);
                rcnt_q <= rcnt_q + ADDR_WIDTH'(1);
            end

            if (w_rd_acc) begin
                dout_q <= mem_q[rp_q];
            end

            // Clear on (re)arm first so a coincident late edge still counts.
            if (w_rearm) begin
                overrun_q <= 1'b0;
            end
            if (w_trig_ev && ((state_q == S_POSTTRIG) || (state_q == S_READOUT))) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Buffer write port
    always_ff @(posedge Clock_i) begin
        if (w_we) begin
            mem_q[wp_q] <= DataIn_i;
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_q;
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
            if (w_accept) begin
                ts_q <= ts_cnt_q;
            end
        end
    end

    assign TrigTimestamp_o = ts_q;
`else
    assign TrigTimestamp_o = '0;
`endif

    assign DataOut_o   = dout_q;
    assign DataValid_o = dvalid_q;
    assign Triggered_o = triggered_q;
    assign Overrun_o   = overrun_q;
    assign State_o     = state_q;

endmodule

`default_nettype wire
